// File: rtl/simon_pkg.sv
// Shared definitions for the pattern player and the game controller.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
//
// Contents: default pattern-memory address width, playback state encoding,
// and the colour code to one-hot LED mapping.
package simon_pkg;

    // Pattern memory depth is 2**ADDR_W_DEF entries.
    localparam int ADDR_W_DEF = 6;

    // Playback state encoding. Kept as plain constants so older blocks that
    // compare against raw 3-bit codes keep working.
    typedef logic [2:0] pb_state_t;

    localparam pb_state_t ST_IDLE  = 3'd0;
    localparam pb_state_t ST_FETCH = 3'd1;
    localparam pb_state_t ST_LATCH = 3'd2;
    localparam pb_state_t ST_SHOW  = 3'd3;
    localparam pb_state_t ST_GAP   = 3'd4;
    localparam pb_state_t ST_DONE  = 3'd5;

    // Colour code to LED lamp: 00->0001, 01->0010, 10->0100, 11->1000.
    function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
        logic [3:0] lamp;
        lamp = 4'b0000;
        case (colour)
            2'd0:    lamp = 4'b0001;
            2'd1:    lamp = 4'b0010;
            2'd2:    lamp = 4'b0100;
            default: lamp = 4'b1000;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Counts tick strobes while enabled and flags the limit-th one.
// Latency: expired_o is combinational in the cycle of the terminal tick.
// Backpressure: none; every tick seen while enabled is counted.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        synchronous clear (wins over counting)
//   en_i         count ticks this cycle
//   tick_i       one-clk timing strobe
//   limit_i      number of ticks to the terminal count (must be >= 1)
//   expired_o    high on the tick that reaches limit_i; counter self-clears
module tick_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    // The counter holds ticks already seen, so the next tick is the last one
    // when limit-1 have been counted.
    assign at_last   = (cnt_q == (limit_i - CNT_ONE));
    assign expired_o = en_i & tick_i & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && tick_i) begin
            cnt_d = at_last ? '0 : (cnt_q + CNT_ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/playback_sequencer.sv
// Plays a stored colour pattern on a one-hot LED set, one entry per ON/GAP window.
// Latency: start -> first lamp lit after 2 clk (fetch + latch); each entry ON_TICKS lit + GAP_TICKS dark.
// Backpressure: none; start while busy is dropped, abort cancels on the next clk.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   tick       one-clk 100 Hz strobe, counted only in SHOW and GAP
//   start      one-clk request to play 'length' entries from address 0
//   abort      level; returns to IDLE on the next clk, no done
//   length     entries to play, saturated to 2**ADDR_W on capture
//   mem_addr   pattern memory read address
//   mem_data   pattern memory data, one clk after mem_addr
//   leds       one-hot colour while lit, 0000 when dark
//   busy       high whenever not IDLE
//   done       one-clk pulse on normal completion
module playback_sequencer
    import simon_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ON_TICKS  = 50,
    parameter int GAP_TICKS = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        leds,
    output logic              busy,
    output logic              done
);

    localparam int MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    // +1 so the limit value itself is representable.
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0]  ON_LIM   = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0]  GAP_LIM  = CNT_W'(GAP_TICKS);
    localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    pb_state_t         state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        colour_q, colour_d;

    logic [ADDR_W:0]   len_sat;
    logic              last_entry;
    logic              timer_clr;
    logic              timer_en;
    logic [CNT_W-1:0]  timer_lim;
    logic              timer_expired;

    assign len_sat    = (length > LEN_MAX) ? LEN_MAX : length;
    // idx == len-1, written as idx+1 == len so len never has to be decremented.
    assign last_entry = (({1'b0, idx_q} + LEN_ONE) == len_q);

    tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .tick_i    (tick),
        .limit_i   (timer_lim),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        colour_d  = colour_q;
        // The timer sits cleared outside SHOW/GAP, so ticks there never count
        // and every window starts from zero.
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        timer_lim = ON_LIM;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    len_d   = len_sat;
                    idx_d   = '0;
                    addr_d  = '0;
                    state_d = (len_sat == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Memory read latency slot.
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                colour_d = mem_data;
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                timer_lim = ON_LIM;
                if (timer_expired) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                timer_lim = GAP_LIM;
                if (timer_expired) begin
                    if (last_entry) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_ONE;
                        addr_d  = idx_q + ADDR_ONE;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats everything, including a GAP expiry in the same clk;
        // address and index are left where they were.
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            idx_d     = idx_q;
            addr_d    = addr_q;
            colour_d  = colour_q;
            timer_clr = 1'b1;
            timer_en  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            colour_q <= colour_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them
    // without waiting for a clock edge.
    assign mem_addr = addr_q;
    assign leds     = (state_q == ST_SHOW) ? colour_onehot(colour_q) : 4'b0000;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: directed scenarios, scoreboard of display events.
// Latency: n/a.
// Backpressure: n/a.
module tb_playback_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic       abort;
    logic [6:0] length;
    logic [5:0] mem_addr;
    logic [1:0] mem_data;
    logic [3:0] leds;
    logic       busy;
    logic       done;

    playback_sequencer #(
        .ADDR_W    (6),
        .ON_TICKS  (4),
        .GAP_TICKS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .abort    (abort),
        .length   (length),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .leds     (leds),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern memory model: registered read, one clk latency.
    logic [1:0] mem [64];
    always_ff @(posedge clk) mem_data <= mem[mem_addr];

    // Display events: SHOW(lamp, ticks lit), GAP(ticks dark), DONE(cycle), IDLE(cycle).
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  lamp;
        logic [15:0] val;
    } ev_t;

    localparam logic [1:0] K_SHOW = 2'd0;
    localparam logic [1:0] K_GAP  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_IDLE = 2'd3;

    ev_t exp_q[$];
    int  total;
    int  bad;
    int  ph;         // cycle index since the last start
    int  max_addr;
    int  prev_addr;
    bit  wrap;

    function automatic ev_t mk(input logic [1:0] k, input logic [3:0] l, input int v);
        ev_t e;
        e.kind = k;
        e.lamp = l;
        e.val  = v[15:0];
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic emit(input logic [1:0] k, input logic [3:0] l, input int v);
        ev_t got;
        ev_t want;
        got = mk(k, l, v);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected event: kind=%0d lamp=%b val=%0d", got.kind, got.lamp, got.val);
        end else begin
            want = exp_q.pop_front();
            if (got != want) begin
                bad++;
                $display("FAIL event: got kind=%0d lamp=%b val=%0d, expected kind=%0d lamp=%b val=%0d",
                         got.kind, got.lamp, got.val, want.kind, want.lamp, want.val);
            end
        end
    endtask

    // Monitor: samples on the falling edge and turns output activity into events.
    initial begin
        bit         in_lit;
        bit         in_gap;
        bit         prev_busy;
        logic [3:0] lit_lamp;
        int         lit_ticks;
        int         gap_ticks;
        in_lit    = 1'b0;
        in_gap    = 1'b0;
        prev_busy = 1'b0;
        lit_lamp  = 4'b0;
        lit_ticks = 0;
        gap_ticks = 0;
        forever begin
            @(negedge clk);
            if (in_lit && leds == 4'b0) begin
                emit(K_SHOW, lit_lamp, lit_ticks);
                in_lit    = 1'b0;
                in_gap    = 1'b1;
                gap_ticks = 0;
            end
            if (in_gap && (leds != 4'b0 || done || !busy)) begin
                emit(K_GAP, 4'b0, gap_ticks);
                in_gap = 1'b0;
            end
            if (leds != 4'b0) begin
                if (!in_lit) begin
                    in_lit    = 1'b1;
                    lit_lamp  = leds;
                    lit_ticks = 0;
                end
                if (tick) lit_ticks++;
            end
            if (in_gap && tick) gap_ticks++;
            if (done) emit(K_DONE, 4'b0, ph);
            if (prev_busy && !busy) emit(K_IDLE, 4'b0, ph);
            prev_busy = busy;
        end
    end

    // One clk of stimulus: ticks land on every 10th cycle after a start.
    task automatic next_cyc();
        @(posedge clk);
        #1;
        ph++;
        tick  = (ph % 10 == 0);
        start = 1'b0;
        abort = 1'b0;
        if (busy) begin
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (int'(mem_addr) < prev_addr) wrap = 1'b1;
            prev_addr = int'(mem_addr);
        end
    endtask

    task automatic kick(input logic [6:0] len);
        next_cyc();
        ph        = 0;
        tick      = 1'b0;
        start     = 1'b1;
        length    = len;
        max_addr  = 0;
        prev_addr = 0;
        wrap      = 1'b0;
    endtask

    task automatic run_to(input int p);
        while (ph < p) next_cyc();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            next_cyc();
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load3();
        for (int i = 0; i < 64; i++) mem[i] = 2'd0;
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
    endtask

    task automatic push3();
        exp_q.push_back(mk(K_SHOW, 4'b0100, 4));
        exp_q.push_back(mk(K_GAP,  4'b0000, 2));
        exp_q.push_back(mk(K_SHOW, 4'b0001, 4));
        exp_q.push_back(mk(K_GAP,  4'b0000, 2));
        exp_q.push_back(mk(K_SHOW, 4'b1000, 4));
        exp_q.push_back(mk(K_GAP,  4'b0000, 2));
        exp_q.push_back(mk(K_DONE, 4'b0000, 181));
        exp_q.push_back(mk(K_IDLE, 4'b0000, 182));
    endtask

    task automatic push64(input logic [3:0] lamp);
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(mk(K_SHOW, lamp, 4));
            exp_q.push_back(mk(K_GAP,  4'b0000, 2));
        end
        exp_q.push_back(mk(K_DONE, 4'b0000, 3841));
        exp_q.push_back(mk(K_IDLE, 4'b0000, 3842));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ph        = 0;
        max_addr  = 0;
        prev_addr = 0;
        wrap      = 1'b0;
        rst       = 1'b1;
        tick      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        length    = 7'd0;
        load3();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_leds", int'(leds), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(mem_addr), 0);
        rst = 1'b0;
        repeat (3) next_cyc();

        // Three-entry pattern {2,0,3}.
        push3();
        kick(7'd3);
        drain("run3_drain");
        check("run3_max_addr", max_addr, 2);
        check("run3_wrap", int'(wrap), 0);

        // Re-start mid-SHOW of entry 1 and a length change after capture.
        push3();
        kick(7'd3);
        run_to(5);
        length = 7'd1;
        run_to(80);
        start = 1'b1;
        drain("restart_drain");
        check("restart_max_addr", max_addr, 2);

        // Abort in the gap after entry 0, then replay from address 0.
        exp_q.push_back(mk(K_SHOW, 4'b0100, 4));
        exp_q.push_back(mk(K_GAP,  4'b0000, 0));
        exp_q.push_back(mk(K_IDLE, 4'b0000, 46));
        kick(7'd3);
        run_to(45);
        abort = 1'b1;
        next_cyc();
        check("abort_busy", int'(busy), 0);
        check("abort_leds", int'(leds), 0);
        check("abort_done", int'(done), 0);
        drain("abort_drain");
        push3();
        kick(7'd3);
        next_cyc();
        check("replay_addr", int'(mem_addr), 0);
        drain("replay_drain");

        // Zero length: immediate done, no fetches.
        exp_q.push_back(mk(K_DONE, 4'b0000, 1));
        exp_q.push_back(mk(K_IDLE, 4'b0000, 2));
        kick(7'd0);
        drain("len0_drain");
        check("len0_max_addr", max_addr, 0);

        // Full memory, all colour 1.
        for (int i = 0; i < 64; i++) mem[i] = 2'd1;
        push64(4'b0010);
        kick(7'd64);
        drain("len64_drain");
        check("len64_max_addr", max_addr, 63);
        check("len64_wrap", int'(wrap), 0);

        // Oversized length saturates to 64 entries.
        for (int i = 0; i < 64; i++) mem[i] = 2'd3;
        push64(4'b1000);
        kick(7'd100);
        drain("sat_drain");
        check("sat_max_addr", max_addr, 63);

        // Asynchronous reset during SHOW of entry 0.
        load3();
        exp_q.push_back(mk(K_SHOW, 4'b0100, 1));
        exp_q.push_back(mk(K_GAP,  4'b0000, 0));
        exp_q.push_back(mk(K_IDLE, 4'b0000, 15));
        kick(7'd3);
        run_to(15);
        #2;
        rst = 1'b1;
        #1;
        check("arst_leds", int'(leds), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_addr", int'(mem_addr), 0);
        next_cyc();
        next_cyc();
        rst = 1'b0;
        repeat (40) next_cyc();
        drain("arst_drain");

        repeat (20) next_cyc();
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, pattern memory address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter ON_TICKS, default 50, tick pulses each colour is lit (0.5 s at 100 Hz).
REQ-003 SHALL have parameter GAP_TICKS, default 25, tick pulses of dark gap after each colour.
REQ-004 clk  input  1  system clock; the one clock, all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick  input  1  one-clk-wide timing strobe from the 100 Hz clock divider.
REQ-007 start  input  1  one-clk pulse; begin playback of the stored pattern.
REQ-008 abort  input  1  level; cancel playback.
REQ-009 length  input  ADDR_W+1  number of pattern entries to play (0..2**ADDR_W).
REQ-010 mem_addr  output  ADDR_W  read address to pattern memory.
REQ-011 mem_data  input  2  pattern memory read data, valid one clk after mem_addr changes.
REQ-012 leds  output  4  one-hot colour display (00->0001, 01->0010, 10->0100, 11->1000), 0000 when dark.
REQ-013 busy  output  1  high from the clk after an accepted start until return to IDLE.
REQ-014 done  output  1  one-clk pulse at normal completion.

Function
REQ-015 SHALL implement states IDLE, FETCH, LATCH, SHOW, GAP, DONE.
REQ-016 IDLE: on start, SHALL capture length (saturated to 2**ADDR_W), clear index to 0, drive mem_addr=0, go to FETCH; if the captured length is 0, go directly to DONE.
REQ-017 FETCH SHALL last exactly one clk (memory latency), then go to LATCH.
REQ-018 LATCH SHALL register mem_data into a colour register, clear the tick counter, and go to SHOW.
REQ-019 SHOW SHALL drive leds=onehot(colour) and count tick pulses; on the ON_TICKS-th tick it SHALL clear the counter and go to GAP.
REQ-020 GAP SHALL drive leds=0000 and count ticks; on the GAP_TICKS-th tick, if index==length-1 it SHALL go to DONE, else increment index, set mem_addr=index+1, and go to FETCH.
REQ-021 DONE SHALL assert done for exactly one clk, then go to IDLE.
REQ-022 Ticks arriving in IDLE, FETCH, LATCH or DONE SHALL NOT be counted.
REQ-023 start while busy SHALL be ignored; length changes after capture SHALL have no effect.
REQ-024 abort high in any state other than IDLE SHALL force IDLE on the next clk with leds=0000 and busy=0, and no done; abort overrides a simultaneous start.
REQ-025 mem_addr SHALL hold its value except at the transitions in REQ-016/020; index SHALL never exceed length-1.
REQ-026 Counter SHALL be wide enough for max(ON_TICKS,GAP_TICKS) without wrap.

Reset
REQ-027 rst high SHALL asynchronously force state IDLE, mem_addr=0, leds=0000, busy=0, done=0, index=0, counter=0, colour=0.
REQ-028 rst mid-playback SHALL abandon the sequence; no done after release.

Structure
REQ-029 State encoding, colour-to-one-hot mapping and ADDR_W default SHALL live in the shared simon_pkg package, also used by game_fsm.
REQ-030 The tick counter with terminal-count compare MAY be one sub-module, tick_timer; everything else is in playback_sequencer.

Verification
REQ-031 Memory preloaded {2,0,3}, length=3, ON=4, GAP=2, tick every 10 clk: leds show 0100, 0001, 1000, each for 4 ticks separated by 2 dark ticks; exactly one done; busy then drops.
REQ-032 length=0, start -> done pulse within 3 clk, leds stay 0000, no memory address other than 0.
REQ-033 length=64, all entries 1 -> 64 SHOW windows of 0010, mem_addr reaches 63 and never wraps to 0 before done.
REQ-034 start pulsed again mid-SHOW of entry 1 -> ignored; sequence and done timing identical to the undisturbed run.
REQ-035 abort asserted in GAP after entry 0 -> next clk IDLE, leds 0000, busy 0, no done; new start replays from address 0.
REQ-036 rst asserted during SHOW asynchronously -> leds 0000 and busy 0 before the next clk edge, all outputs at reset values.
